// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 multi-port register file.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 64;

    // Index of the hardwired zero register (XZR) for a file of nreg entries.
    function automatic int XZR_OFFSET(input int nreg);
        return nreg - 1;
    endfunction

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset sequencer: walks every storable register once, loading it with its
// own index, then raises ready and hands the write path over to the ports.
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              ready_o,
    output logic              init_we_o,
    output logic [AW-1:0]     init_addr_o,
    output logic [DATA_W-1:0] init_data_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(XZR_OFFSET(NREG) - 1);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            INIT: begin
                // XZR is never stored, so the walk stops one short of NREG-1.
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: ;
            default: begin
                state_d = INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign ready_o     = ready_q;
    assign init_we_o   = (state_q == INIT) && !reset_i;
    assign init_addr_o = cnt_q;
    assign init_data_o = DATA_W'(cnt_q);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port LEGv8 integer register file: NRD combinational reads, two write
// ports (ALU, load) with load priority, XZR hardwired to zero.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  we2,
    input  logic [AW-1:0]         wa2,
    input  logic [DATA_W-1:0]     wd2,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic                  ready,
    output logic                  wr_conflict
);

    localparam logic [AW-1:0] XZR = AW'(XZR_OFFSET(NREG));

    logic [DATA_W-1:0] regs_q [NREG-1];

    logic              init_we;
    logic [AW-1:0]     init_addr;
    logic [DATA_W-1:0] init_data;
    logic              w1_ok, w2_ok;
    logic              wr_conflict_q, wr_conflict_d;

    regfile_init_fsm #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_init (
        .clk_i       (clk),
        .reset_i     (reset),
        .ready_o     (ready),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_data_o (init_data)
    );

    // Port writes are only live in RUN and are dropped on a reset edge.
    assign w1_ok = ready && !reset && we1 && (wa1 != XZR);
    assign w2_ok = ready && !reset && we2 && (wa2 != XZR);
    assign wr_conflict_d = w1_ok && w2_ok && (wa1 == wa2);

    // Port 2 is written last so a load overrides an ALU write to the same register.
    always_ff @(posedge clk) begin
        if (init_we) begin
            regs_q[init_addr] <= init_data;
        end else begin
            if (w1_ok) regs_q[wa1] <= wd1;
            if (w2_ok) regs_q[wa2] <= wd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wr_conflict_q <= 1'b0;
        else       wr_conflict_q <= wr_conflict_d;
    end

    assign wr_conflict = wr_conflict_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] val;

        assign addr = ra[g*AW +: AW];

        always_comb begin
            val = '0;
            if (ready && (addr != XZR)) begin
                val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
                if (w1_ok && (wa1 == addr)) val = wd1;
                if (w2_ok && (wa2 == addr)) val = wd2;
`endif
            end
        end

        assign rd[g*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default NREG=32, NRD=2, DATA_W=64).
module tb_regfile_mp;

    localparam int DATA_W = 64;
    localparam int NREG   = 32;
    localparam int NRD    = 2;
    localparam int AW     = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  we1, we2;
    logic [AW-1:0]         wa1, wa2;
    logic [DATA_W-1:0]     wd1, wd2;
    logic [NRD*AW-1:0]     ra;
    logic [NRD*DATA_W-1:0] rd;
    logic                  ready;
    logic                  wr_conflict;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .NRD    (NRD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .we2         (we2),
        .wa2         (wa2),
        .wd2         (wd2),
        .ra          (ra),
        .rd          (rd),
        .ready       (ready),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_ports();
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        we2 = 1'b0; wa2 = '0; wd2 = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
        settle();
    endtask

    function automatic logic [DATA_W-1:0] rd0();
        return rd[0 +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rd1();
        return rd[DATA_W +: DATA_W];
    endfunction

    // Counts the edges from the first reset-low cycle and checks ready timing.
    task automatic run_init(input string pfx);
        for (int e = 1; e <= 31; e++) begin
            if (e == 10) begin
                we1 = 1'b1; wa1 = 5'd3; wd1 = 64'hDEAD;
            end
            tick();
            if (e == 10) idle_ports();
            if (e == 1)  check_eq({pfx, "_ready_e1"}, 64'(ready), 64'd0);
            if (e == 5)  check_eq({pfx, "_rd_in_init"}, rd0(), 64'd0);
            if (e == 30) check_eq({pfx, "_ready_e30"}, 64'(ready), 64'd0);
            if (e == 31) check_eq({pfx, "_ready_e31"}, 64'(ready), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_ports();
        ra = '0;
        tick();
        tick();
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_conflict", 64'(wr_conflict), 64'd0);

        reset = 1'b0;
        set_ra(5'd5, 5'd31);
        run_init("init");

        set_ra(5'd5, 5'd31);
        check_eq("init_r5", rd0(), 64'd5);
        check_eq("init_xzr", rd1(), 64'd0);
        set_ra(5'd3, 5'd30);
        check_eq("init_r3_dropped", rd0(), 64'd3);
        check_eq("init_r30", rd1(), 64'd30);
        set_ra(5'd0, 5'd1);
        check_eq("init_r0", rd0(), 64'd0);
        check_eq("init_r1", rd1(), 64'd1);

        // XZR write discarded
        we1 = 1'b1; wa1 = 5'd31; wd1 = 64'hFFFF;
        set_ra(5'd31, 5'd0);
        check_eq("xzr_same_cycle", rd0(), 64'd0);
        tick();
        idle_ports();
        set_ra(5'd31, 5'd0);
        check_eq("xzr_next", rd0(), 64'd0);
        check_eq("xzr_no_conflict", 64'(wr_conflict), 64'd0);

        // Dual write, same address: load wins
        we1 = 1'b1; wa1 = 5'd7; wd1 = 64'hA;
        we2 = 1'b1; wa2 = 5'd7; wd2 = 64'hB;
        tick();
        idle_ports();
        set_ra(5'd7, 5'd0);
        check_eq("dual_r7", rd0(), 64'hB);
        check_eq("dual_conflict_hi", 64'(wr_conflict), 64'd1);
        tick();
        check_eq("dual_conflict_lo", 64'(wr_conflict), 64'd0);

        // Back-to-back conflicts keep the flag high
        we1 = 1'b1; wa1 = 5'd8; wd1 = 64'h81;
        we2 = 1'b1; wa2 = 5'd8; wd2 = 64'h82;
        tick();
        check_eq("b2b_conflict_1", 64'(wr_conflict), 64'd1);
        wd1 = 64'h91; wd2 = 64'h92;
        tick();
        check_eq("b2b_conflict_2", 64'(wr_conflict), 64'd1);
        idle_ports();
        tick();
        check_eq("b2b_conflict_end", 64'(wr_conflict), 64'd0);
        set_ra(5'd8, 5'd8);
        check_eq("b2b_r8", rd1(), 64'h92);

        // Both ports, different addresses
        we1 = 1'b1; wa1 = 5'd10; wd1 = 64'h111;
        we2 = 1'b1; wa2 = 5'd11; wd2 = 64'h222;
        tick();
        idle_ports();
        set_ra(5'd10, 5'd11);
        check_eq("diff_r10", rd0(), 64'h111);
        check_eq("diff_r11", rd1(), 64'h222);
        check_eq("diff_no_conflict", 64'(wr_conflict), 64'd0);

        // Same-cycle read of a register being written
        we2 = 1'b1; wa2 = 5'd9; wd2 = 64'h1234;
        set_ra(5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
        check_eq("byp_p2_same", rd1(), 64'h1234);
`else
        check_eq("byp_p2_same", rd1(), 64'd9);
`endif
        tick();
        idle_ports();
        set_ra(5'd0, 5'd9);
        check_eq("byp_p2_next", rd1(), 64'h1234);

        we1 = 1'b1; wa1 = 5'd12; wd1 = 64'h77;
        set_ra(5'd12, 5'd0);
`ifdef REGFILE_BYPASS_EN
        check_eq("byp_p1_same", rd0(), 64'h77);
`else
        check_eq("byp_p1_same", rd0(), 64'd12);
`endif
        tick();
        idle_ports();
        set_ra(5'd12, 5'd0);
        check_eq("byp_p1_next", rd0(), 64'h77);

        // Mid-run reset restarts initialisation; write on the reset edge is lost
        we1 = 1'b1; wa1 = 5'd4; wd1 = 64'h55;
        tick();
        idle_ports();
        set_ra(5'd4, 5'd0);
        check_eq("mid_r4_written", rd0(), 64'h55);
        reset = 1'b1;
        we2 = 1'b1; wa2 = 5'd6; wd2 = 64'h99;
        tick();
        idle_ports();
        reset = 1'b0;
        check_eq("mid_ready_drop", 64'(ready), 64'd0);
        check_eq("mid_conflict_clr", 64'(wr_conflict), 64'd0);
        run_init("reinit");
        set_ra(5'd4, 5'd6);
        check_eq("reinit_r4", rd0(), 64'd4);
        check_eq("reinit_r6", rd1(), 64'd6);
        set_ra(5'd7, 5'd9);
        check_eq("reinit_r7", rd0(), 64'd7);
        check_eq("reinit_r9", rd1(), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
